// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered value, guard blanking and leading-zero suppression.
// Outputs are decoded from registered state only; a load is acknowledged one cycle later and committed at the frame boundary.
module fnd_scan_controller #(
    parameter int P_CLK_DIV  = 100000,
    parameter int P_GUARD    = 2,
    parameter int P_LZ_BLANK = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_Load,
    input  logic [15:0] i_Value,
    input  logic        i_Blank,
    output logic [1:0]  o_DigitSelect,
    output logic        o_EN,
    output logic [3:0]  o_BCD,
    output logic        o_LoadAck,
    output logic        o_Pending,
    output logic        o_FrameTick
);
    localparam int CW = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;

    logic [CW-1:0] prescaler;
    logic [1:0]    select;
    logic [15:0]   shadow;
    logic [15:0]   display;
    logic          pending;
    logic          blank_q;
    logic          load_ack;
    logic          frame_tick;

    logic slot_end;
    logic frame_end;
    logic commit;
    logic lz_suppress;
    logic [3:0] nibble;

    assign slot_end  = (prescaler == CW'(P_CLK_DIV - 1));
    assign frame_end = slot_end && (select == 2'd3);
    // Commit only at the very last cycle of the frame so the whole next frame shows one value.
    assign commit    = frame_end && pending;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prescaler  <= '0;
            select     <= 2'd0;
            shadow     <= 16'h0000;
            display    <= 16'h0000;
            pending    <= 1'b0;
            blank_q    <= 1'b0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            if (slot_end) begin
                prescaler <= '0;
                select    <= select + 2'd1;
            end else begin
                prescaler <= prescaler + CW'(1);
            end
            if (commit) begin
                display <= shadow;
            end
            if (i_Load) begin
                shadow  <= i_Value;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            load_ack   <= i_Load;
            blank_q    <= i_Blank;
            frame_tick <= frame_end;
        end
    end

    always_comb begin
        nibble      = 4'h0;
        lz_suppress = 1'b0;
        case (select)
            2'd0: nibble = display[3:0];
            2'd1: nibble = display[7:4];
            2'd2: nibble = display[11:8];
            default: nibble = display[15:12];
        endcase
        // A digit is dark when it and every digit to its left are zero; digit 0 always shows.
        case (select)
            2'd1: lz_suppress = (display[15:4] == 12'h000);
            2'd2: lz_suppress = (display[15:8] == 8'h00);
            2'd3: lz_suppress = (display[15:12] == 4'h0);
            default: lz_suppress = 1'b0;
        endcase
        lz_suppress = lz_suppress && (P_LZ_BLANK == 1);
    end

    assign o_DigitSelect = select;
    assign o_BCD         = nibble;
    assign o_EN          = (prescaler < CW'(P_GUARD)) || blank_q || lz_suppress;
    assign o_LoadAck     = load_ack;
    assign o_Pending     = pending;
    assign o_FrameTick   = frame_tick;
endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed and randomized checks of fnd_scan_controller against a cycle-count based reference model.
module tb_fnd_scan_controller;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_Load = 1'b0;
    logic [15:0] i_Value = 16'h0000;
    logic        i_Blank = 1'b0;
    logic [1:0]  o_DigitSelect;
    logic        o_EN;
    logic [3:0]  o_BCD;
    logic        o_LoadAck;
    logic        o_Pending;
    logic        o_FrameTick;

    int tests = 0;
    int fails = 0;

    // Reference model: time since reset release plus the architectural registers.
    int          t = 0;
    logic [15:0] m_sh = 16'h0000;
    logic [15:0] m_disp = 16'h0000;
    bit          m_pend = 0;
    bit          m_blank = 0;
    bit          m_ack = 0;
    bit          m_tick = 0;

    fnd_scan_controller #(.P_CLK_DIV(4), .P_GUARD(1), .P_LZ_BLANK(1)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_Load(i_Load),
        .i_Value(i_Value),
        .i_Blank(i_Blank),
        .o_DigitSelect(o_DigitSelect),
        .o_EN(o_EN),
        .o_BCD(o_BCD),
        .o_LoadAck(o_LoadAck),
        .o_Pending(o_Pending),
        .o_FrameTick(o_FrameTick)
    );

    always #5 i_clk = ~i_clk;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        int sel;
        logic [15:0] upper;
        bit exp_en;
        sel   = (t / 4) % 4;
        upper = m_disp >> (4 * sel);
        exp_en = ((t % 4) < 1) || m_blank || (sel != 0 && upper == 16'h0000);
        cmp("select",  {14'd0, o_DigitSelect}, 16'(sel));
        cmp("bcd",     {12'd0, o_BCD}, upper & 16'h000F);
        cmp("en",      {15'd0, o_EN}, {15'd0, exp_en});
        cmp("loadack", {15'd0, o_LoadAck}, {15'd0, m_ack});
        cmp("pending", {15'd0, o_Pending}, {15'd0, m_pend});
        cmp("frametick", {15'd0, o_FrameTick}, {15'd0, m_tick});
    endtask

    task automatic model_reset();
        t = 0; m_sh = 0; m_disp = 0; m_pend = 0; m_blank = 0; m_ack = 0; m_tick = 0;
    endtask

    task automatic model_edge(input bit l, input logic [15:0] v, input bit b);
        bit commit;
        commit = ((t % 4) == 3) && (((t / 4) % 4) == 3) && m_pend;
        if (commit) m_disp = m_sh;
        if (l) begin
            m_sh = v;
            m_pend = 1;
        end else if (commit) begin
            m_pend = 0;
        end
        m_ack = l;
        m_blank = b;
        t++;
        m_tick = ((t % 16) == 0);
    endtask

    task automatic step(input bit l, input logic [15:0] v, input bit b);
        i_Load = l; i_Value = v; i_Blank = b;
        @(posedge i_clk);
        model_edge(l, v, b);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0000, 0);
    endtask

    // Advance until the cycle whose frame position (t mod 16) equals ph.
    task automatic run_to(input int ph);
        for (int i = 0; i < 16 && (t % 16) != ph; i++) step(0, 16'h0000, 0);
    endtask

    task automatic reset_hold(input int n);
        i_reset = 1'b1; i_Load = 0; i_Blank = 0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
            check_all();
        end
        i_reset = 1'b0;
    endtask

    initial begin
        #2;
        reset_hold(3);

        // Free-running scan with blank display.
        idle(20);

        // Load in the middle of the digit-1 slot and watch it commit.
        run_to(5);
        step(1, 16'h1234, 0);
        idle(30);

        // Leading-zero suppression on 0050.
        step(1, 16'h0050, 0);
        idle(34);

        // Load in the commit cycle while 1111 is pending.
        run_to(2);
        step(1, 16'h1111, 0);
        run_to(15);
        step(1, 16'hAAAA, 0);
        cmp("display_after_commit", {12'd0, o_BCD}, 16'h0001);
        idle(34);

        // Back-to-back loads: last one wins.
        step(1, 16'h9876, 0);
        step(1, 16'h0F0E, 0);
        step(1, 16'h00C3, 0);
        idle(34);

        // Six-cycle blank pulse.
        run_to(1);
        for (int i = 0; i < 6; i++) step(0, 16'h0000, 1);
        idle(8);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) == 0, 16'($urandom), ($urandom % 10) == 0);
        end
        idle(34);

        // Reset in the digit-2 slot with a value pending: nothing may survive.
        step(1, 16'h4321, 0);
        idle(34);
        run_to(9);
        step(1, 16'h8765, 0);
        cmp("pending_before_reset", {15'd0, o_Pending}, 16'h0001);
        #2;
        reset_hold(2);
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 Parameter P_CLK_DIV, default 100000, is the number of clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter P_GUARD, default 2, is the number of anti-ghost blank cycles at the start of each slot; legal range 1..P_CLK_DIV-2.
REQ-003 Parameter P_LZ_BLANK, default 1, enables leading-zero suppression when 1.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_Load  input  1  capture request for i_Value, sampled every cycle.
REQ-007 i_Value  input  16  four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 i_Blank  input  1  forces all digits off while high.
REQ-009 o_DigitSelect  output  2  index of the active digit, feeds the digit-select decoder.
REQ-010 o_EN  output  1  decoder disable, 1 = all digits off, 0 = selected digit on.
REQ-011 o_BCD  output  4  nibble of the active digit.
REQ-012 o_LoadAck  output  1  one-cycle pulse confirming a capture.
REQ-013 o_Pending  output  1  high while a captured value awaits commit.
REQ-014 o_FrameTick  output  1  one-cycle pulse at the start of each frame.

Function
REQ-015 Prescaler counts 0..P_CLK_DIV-1 and wraps to 0; each wrap advances o_DigitSelect by 1, with 3 wrapping to 0; one frame = 4*P_CLK_DIV cycles.
REQ-016 Two 16-bit registers: shadow (written by load) and display (drives outputs).
REQ-017 i_Load=1 in cycle N: shadow <= i_Value, o_Pending=1 and o_LoadAck=1 in cycle N+1; o_LoadAck=0 in cycle N+2 unless another load occurs.
REQ-018 Back-to-back loads: each is captured; the last value wins; o_LoadAck pulses once per load.
REQ-019 Commit: when prescaler==P_CLK_DIV-1 and o_DigitSelect==3 and o_Pending==1, display <= shadow and o_Pending <= 0; display never changes at any other time (no tearing).
REQ-020 Load in the commit cycle: commit uses the old shadow; the new value enters shadow; o_Pending stays 1.
REQ-021 o_FrameTick = 1 exactly in the first cycle of each digit-0 slot (prescaler==0, select==0), whether or not a commit occurred.
REQ-022 o_BCD = display nibble indexed by o_DigitSelect, passed unmodified, including non-BCD values A-F.
REQ-023 o_EN = 1 when prescaler < P_GUARD, or the registered blank flag is 1, or the slot is leading-zero suppressed; otherwise 0.
REQ-024 Leading-zero suppression (P_LZ_BLANK=1): digit k in 1..3 is suppressed when display nibbles k..3 are all zero; digit 0 is never suppressed.
REQ-025 i_Blank is registered; its effect on o_EN appears one cycle after it changes; scanning and commit continue while blanked.
REQ-026 All outputs derive from registered state only; there is no combinational path from any input to any output.

Reset
REQ-027 While i_reset=1, asynchronously: prescaler=0, select=0, shadow=0, display=0, pending=0, blank flag=0.
REQ-028 Output values during and after reset: o_DigitSelect=0, o_BCD=0, o_EN=1, o_LoadAck=0, o_Pending=0, o_FrameTick=0.
REQ-029 Reset asserted mid-slot or mid-commit discards any pending value; on release, scanning restarts at the digit-0 slot, prescaler=0.
REQ-030 The first o_FrameTick after reset release occurs at the first wrap from digit 3 to digit 0, not in the release cycle.

Verification (P_CLK_DIV=4, P_GUARD=1, P_LZ_BLANK=1)
REQ-031 Reset release, no load -> o_DigitSelect sequence 0,1,2,3 changes every 4 cycles; o_EN=0 only in digit-0 slot cycles 1-3; o_BCD=0.
REQ-032 Load 16'h1234 mid digit-1 slot -> o_LoadAck one pulse; o_Pending=1 until the end of the digit-3 slot; next frame o_BCD = 4,3,2,1 for digits 0..3.
REQ-033 Load 16'h0050 and wait for commit -> digit 3 and digit 2 slots have o_EN=1 throughout; digit 1 shows 5; digit 0 shows 0 with o_EN=0 after guard.
REQ-034 Load 16'hAAAA exactly in the commit cycle while 16'h1111 is pending -> display=1111; o_Pending stays 1; 16'hAAAA commits one frame later.
REQ-035 i_Blank=1 for 6 cycles -> o_EN=1 from the next cycle through 1 cycle after deassertion; o_DigitSelect sequence is uninterrupted.
REQ-036 Reset pulse while o_Pending=1 in the digit-2 slot -> all outputs take REQ-028 values immediately; the old display is lost and the pending value is never committed.
